control_unit: RTL and testbench

Hardwired Moore sequencer that drives the control inputs of `datapath`. It replaces hand-timed testbench stimulus.
- Fetches each instruction (T0–T2) and decodes IR.
- Executes register-format ALU, mul/div, neg/not, nop and halt instructions through T3–T6.
- Sits beside `datapath` and feeds its control ports. IR, the memory-ready strobe and a run enable are its only inputs.

---
 rtl/control_unit_pkg.sv | 55 +++++
 rtl/control_unit_if.sv | 31 +++
 rtl/control_unit_reg_select_decode.sv | 15 +
 rtl/control_unit.sv | 169 ++++++++++++++++
 tb/tb_control_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared opcode, state and IR-field definitions for the hardwired control unit.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01100;
    localparam logic [4:0] OP_NEG  = 5'b01101;
    localparam logic [4:0] OP_NOT  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T1W    = 4'd3,
        ST_T2     = 4'd4,
        ST_DEC    = 4'd5,
        ST_T3     = 4'd6,
        ST_T4     = 4'd7,
        ST_T5     = 4'd8,
        ST_T6     = 4'd9,
        ST_HALTED = 4'd10
    } state_e;

    // Opcodes that run the T3..T5(T6) execute sequence.
    function automatic logic op_exec(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_MUL, OP_DIV, OP_NEG, OP_NOT: op_exec = 1'b1;
            default:                        op_exec = 1'b0;
        endcase
    endfunction

    function automatic logic op_muldiv(input logic [4:0] op);
        op_muldiv = (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic op_unary(input logic [4:0] op);
        op_unary = (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface control_unit_if #(
    parameter int REG_COUNT = 16,
    parameter int OPW       = 5
);
    logic                 run;
    logic                 mem_ready;
    logic [31:0]          IR;
    logic                 PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic                 PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic                 IncPC, Read;
    logic [REG_COUNT-1:0] Rin;
    logic [REG_COUNT-1:0] Rout;
    logic [OPW-1:0]       alu_op;
    logic                 halted;
    logic [3:0]           state_o;

    modport master (
        input  run, mem_ready, IR,
        output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
               PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
               IncPC, Read, Rin, Rout, alu_op, halted, state_o
    );

    modport slave (
        output run, mem_ready, IR,
        input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
               PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
               IncPC, Read, Rin, Rout, alu_op, halted, state_o
    );
endinterface

// File: rtl/control_unit_reg_select_decode.sv
// 4-bit register field to gated one-hot select; fields beyond REG_COUNT select nothing.
module reg_select_decode #(
    parameter int REG_COUNT = 16
) (
    input  logic [3:0]           field_i,
    input  logic                 en_i,
    output logic [REG_COUNT-1:0] onehot_o
);
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            onehot_o[i] = en_i && (field_i == 4'(i));
        end
    end
endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the datapath: fetch, decode, register-format execute.
// Optional macro ILLEGAL_OP_TRAP_EN: undecoded opcodes halt and raise `illegal`.
module control_unit
    import cpu_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int OPW       = 5
) (
    input  logic            Clock,
    input  logic            clear,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic            illegal,
`endif
    control_unit_if.master  bus
);
    localparam logic [3:0] S_IDLE   = ST_IDLE;
    localparam logic [3:0] S_T0     = ST_T0;
    localparam logic [3:0] S_T1     = ST_T1;
    localparam logic [3:0] S_T1W    = ST_T1W;
    localparam logic [3:0] S_T2     = ST_T2;
    localparam logic [3:0] S_DEC    = ST_DEC;
    localparam logic [3:0] S_T3     = ST_T3;
    localparam logic [3:0] S_T4     = ST_T4;
    localparam logic [3:0] S_T5     = ST_T5;
    localparam logic [3:0] S_T6     = ST_T6;
    localparam logic [3:0] S_HALTED = ST_HALTED;

    logic [3:0] state_q, state_d;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic [3:0] rout_field;
    logic       rout_en, rin_en;
    logic       unused_ir;

    assign opcode    = bus.IR[IR_OP_LSB +: 5];
    assign ra        = bus.IR[IR_RA_LSB +: 4];
    assign rb        = bus.IR[IR_RB_LSB +: 4];
    assign rc        = bus.IR[IR_RC_LSB +: 4];
    assign unused_ir = ^bus.IR[IR_RC_LSB-1:0];

    // The DEC state is the pending-decode cycle: IR is stable after the T2 IRin edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.run) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = bus.mem_ready ? S_T2 : S_T1W;
            S_T1W:   if (bus.mem_ready) state_d = S_T2;
            S_T2:    state_d = S_DEC;
            S_DEC: begin
                if (opcode == OP_HALT)
                    state_d = S_HALTED;
                else if (op_exec(opcode))
                    state_d = S_T3;
`ifdef ILLEGAL_OP_TRAP_EN
                else if (opcode != OP_NOP)
                    state_d = S_HALTED;
`endif
                else
                    state_d = bus.run ? S_T0 : S_IDLE;
            end
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = op_muldiv(opcode) ? S_T6 : (bus.run ? S_T0 : S_IDLE);
            S_T6:    state_d = bus.run ? S_T0 : S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (state_q == S_DEC && opcode != OP_HALT && opcode != OP_NOP && !op_exec(opcode))
            illegal_d = 1'b1;
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`endif

    // NEG/NOT have a single source, so T4 drives Rb again instead of Rc.
    assign rout_en    = (state_q == S_T3) || (state_q == S_T4);
    assign rout_field = (state_q == S_T4 && !op_unary(opcode)) ? rc : rb;
    assign rin_en     = (state_q == S_T5) && !op_muldiv(opcode);

    reg_select_decode #(.REG_COUNT(REG_COUNT)) u_rout_dec (
        .field_i  (rout_field),
        .en_i     (rout_en),
        .onehot_o (bus.Rout)
    );

    reg_select_decode #(.REG_COUNT(REG_COUNT)) u_rin_dec (
        .field_i  (ra),
        .en_i     (rin_en),
        .onehot_o (bus.Rin)
    );

    always_comb begin
        bus.PCout    = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.MDRout   = 1'b0;
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IRin     = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.alu_op   = '0;
        case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T1W: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: bus.Yin = 1'b1;
            S_T4: begin
                bus.Zin    = 1'b1;
                bus.alu_op = bus.IR[IR_OP_LSB +: OPW];
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                bus.LOin    = op_muldiv(opcode);
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.halted  = (state_q == S_HALTED);
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch/execute sequences, memory wait, halt, run drop, clear.
module tb_control_unit;
    logic Clock;
    logic clear;
`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal;
`endif

    control_unit_if #(.REG_COUNT(16), .OPW(5)) bus ();

    control_unit #(.REG_COUNT(16), .OPW(5)) dut (
        .Clock   (Clock),
        .clear   (clear),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal (illegal),
`endif
        .bus     (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Control vector bit positions.
    localparam logic [15:0] C_PCOUT  = 16'h8000;
    localparam logic [15:0] C_ZHOUT  = 16'h4000;
    localparam logic [15:0] C_ZLOUT  = 16'h2000;
    localparam logic [15:0] C_MDROUT = 16'h1000;
    localparam logic [15:0] C_PCIN   = 16'h0200;
    localparam logic [15:0] C_IRIN   = 16'h0100;
    localparam logic [15:0] C_MARIN  = 16'h0080;
    localparam logic [15:0] C_MDRIN  = 16'h0040;
    localparam logic [15:0] C_YIN    = 16'h0020;
    localparam logic [15:0] C_ZIN    = 16'h0010;
    localparam logic [15:0] C_HIIN   = 16'h0008;
    localparam logic [15:0] C_LOIN   = 16'h0004;
    localparam logic [15:0] C_INCPC  = 16'h0002;
    localparam logic [15:0] C_READ   = 16'h0001;

    localparam logic [15:0] X_T0  = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
    localparam logic [15:0] X_T1  = C_ZLOUT | C_PCIN | C_READ | C_MDRIN;
    localparam logic [15:0] X_T1W = C_READ | C_MDRIN;
    localparam logic [15:0] X_T2  = C_MDROUT | C_IRIN;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [15:0] ctrl();
        return {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.HIout, bus.LOout,
                bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.Zin,
                bus.HIin, bus.LOin, bus.IncPC, bus.Read};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    initial begin
        clear         = 1'b1;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.IR        = 32'h0;
        #1;
        check("reset_state", 32'(bus.state_o), 32'd0);
        check("reset_ctrl", 32'(ctrl()), 32'd0);
        check("reset_rin", 32'(bus.Rin), 32'd0);
        check("reset_rout", 32'(bus.Rout), 32'd0);
        check("reset_alu", 32'(bus.alu_op), 32'd0);
        check("reset_halted", 32'(bus.halted), 32'd0);
        tick();
        tick();
        clear = 1'b0;
        tick();
        check("idle_hold", 32'(bus.state_o), 32'd0);

        // AND R1,R2,R3
        bus.IR  = 32'h28918000;
        bus.run = 1'b1;
        tick(); check("and_t0_state", 32'(bus.state_o), 32'd1);
        check("and_t0_ctrl", 32'(ctrl()), 32'(X_T0));
        tick(); check("and_t1_state", 32'(bus.state_o), 32'd2);
        check("and_t1_ctrl", 32'(ctrl()), 32'(X_T1));
        tick(); check("and_t2_state", 32'(bus.state_o), 32'd4);
        check("and_t2_ctrl", 32'(ctrl()), 32'(X_T2));
        tick(); check("and_dec_state", 32'(bus.state_o), 32'd5);
        check("and_dec_ctrl", 32'(ctrl()), 32'd0);
        check("and_dec_rout", 32'(bus.Rout), 32'd0);
        tick(); check("and_t3_state", 32'(bus.state_o), 32'd6);
        check("and_t3_rout", 32'(bus.Rout), 32'h0004);
        check("and_t3_ctrl", 32'(ctrl()), 32'(C_YIN));
        tick(); check("and_t4_rout", 32'(bus.Rout), 32'h0008);
        check("and_t4_alu", 32'(bus.alu_op), 32'h05);
        check("and_t4_ctrl", 32'(ctrl()), 32'(C_ZIN));
        tick(); check("and_t5_rin", 32'(bus.Rin), 32'h0002);
        check("and_t5_ctrl", 32'(ctrl()), 32'(C_ZLOUT));
        check("and_t5_alu", 32'(bus.alu_op), 32'd0);
        check("and_t5_rout", 32'(bus.Rout), 32'd0);
        tick(); check("and_next_t0", 32'(bus.state_o), 32'd1);

        // Memory wait: three T1W cycles, then MUL R0,R4,R5
        bus.mem_ready = 1'b0;
        tick(); check("wait_t1", 32'(bus.state_o), 32'd2);
        tick(); check("wait_t1w1_state", 32'(bus.state_o), 32'd3);
        check("wait_t1w1_ctrl", 32'(ctrl()), 32'(X_T1W));
        tick(); check("wait_t1w2_state", 32'(bus.state_o), 32'd3);
        tick(); check("wait_t1w3_state", 32'(bus.state_o), 32'd3);
        check("wait_t1w3_ctrl", 32'(ctrl()), 32'(X_T1W));
        bus.mem_ready = 1'b1;
        tick(); check("wait_t2", 32'(bus.state_o), 32'd4);
        bus.IR = mk_ir(5'b01011, 4'd0, 4'd4, 4'd5);
        tick(); check("mul_dec", 32'(bus.state_o), 32'd5);
        tick(); check("mul_t3_rout", 32'(bus.Rout), 32'h0010);
        tick(); check("mul_t4_rout", 32'(bus.Rout), 32'h0020);
        check("mul_t4_alu", 32'(bus.alu_op), 32'h0B);
        tick(); check("mul_t5_ctrl", 32'(ctrl()), 32'(C_ZLOUT | C_LOIN));
        check("mul_t5_rin", 32'(bus.Rin), 32'd0);
        tick(); check("mul_t6_state", 32'(bus.state_o), 32'd9);
        check("mul_t6_ctrl", 32'(ctrl()), 32'(C_ZHOUT | C_HIIN));
        check("mul_t6_rin", 32'(bus.Rin), 32'd0);
        tick(); check("mul_next_t0", 32'(bus.state_o), 32'd1);

        // NEG R7,R9
        tick(); tick();
        bus.IR = mk_ir(5'b01101, 4'd7, 4'd9, 4'd3);
        tick(); tick(); check("neg_t3_rout", 32'(bus.Rout), 32'h0200);
        tick(); check("neg_t4_rout", 32'(bus.Rout), 32'h0200);
        check("neg_t4_alu", 32'(bus.alu_op), 32'h0D);
        tick(); check("neg_t5_rin", 32'(bus.Rin), 32'h0080);
        tick(); check("neg_next_t0", 32'(bus.state_o), 32'd1);

        // ADD R6,R1,R2 with run dropped during T3
        tick(); tick();
        bus.IR = mk_ir(5'b00011, 4'd6, 4'd1, 4'd2);
        tick(); tick(); check("add_t3", 32'(bus.state_o), 32'd6);
        bus.run = 1'b0;
        tick(); check("add_t4", 32'(bus.state_o), 32'd7);
        check("add_t4_rout", 32'(bus.Rout), 32'h0004);
        tick(); check("add_t5_rin", 32'(bus.Rin), 32'h0040);
        tick(); check("add_park_idle", 32'(bus.state_o), 32'd0);
        check("add_idle_ctrl", 32'(ctrl()), 32'd0);
        tick(); check("add_idle_stay", 32'(bus.state_o), 32'd0);

        // Undecoded opcode 5'b11111
        bus.run = 1'b1;
        tick(); tick(); tick();
        bus.IR = 32'hF8000000;
        tick(); check("ill_dec", 32'(bus.state_o), 32'd5);
        tick();
`ifdef ILLEGAL_OP_TRAP_EN
        check("ill_halted", 32'(bus.state_o), 32'd10);
        check("ill_flag", 32'(illegal), 32'd1);
        tick(); check("ill_flag_hold", 32'(illegal), 32'd1);
        clear = 1'b1;
        #1;
        check("ill_flag_clear", 32'(illegal), 32'd0);
        tick();
        clear = 1'b0;
        tick();
`else
        check("ill_as_nop", 32'(bus.state_o), 32'd1);
`endif

        // NOP: T0,T1,T2,DEC then T0
        check("nop_t0", 32'(bus.state_o), 32'd1);
        tick(); tick();
        bus.IR = mk_ir(5'b11010, 4'd1, 4'd1, 4'd1);
        tick(); check("nop_dec_rin", 32'(bus.Rin), 32'd0);
        tick(); check("nop_next_t0", 32'(bus.state_o), 32'd1);

        // Clear mid-instruction (in T4)
        tick(); tick();
        bus.IR = mk_ir(5'b00100, 4'd2, 4'd3, 4'd4);
        tick(); tick(); tick(); check("clr_t4", 32'(bus.state_o), 32'd7);
        clear = 1'b1;
        #1;
        check("clr_async_state", 32'(bus.state_o), 32'd0);
        check("clr_async_ctrl", 32'(ctrl()), 32'd0);
        check("clr_async_rout", 32'(bus.Rout), 32'd0);
        tick();
        clear = 1'b0;
        tick(); check("clr_restart_t0", 32'(bus.state_o), 32'd1);

        // HALT with run held high
        tick(); tick();
        bus.IR = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            check("halt_flag", 32'(bus.halted), 32'd1);
            check("halt_state", 32'(bus.state_o), 32'd10);
            check("halt_ctrl", 32'(ctrl()), 32'd0);
            tick();
        end
        clear = 1'b1;
        #1;
        check("halt_clear_state", 32'(bus.state_o), 32'd0);
        check("halt_clear_flag", 32'(bus.halted), 32'd0);
        check("halt_clear_ctrl", 32'(ctrl()), 32'd0);
        check("halt_clear_rin", 32'(bus.Rin), 32'd0);
        tick();
        clear = 1'b0;
        bus.run = 1'b0;
        tick(); check("halt_clear_idle", 32'(bus.state_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
